// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: scanout reads take every 4th active-video cycle, buffered CPU
// writes drain in all other cycles; sync signals are delayed to match the colour pipe.
module vga_fb_arbiter #(
    parameter int unsigned CELLS_X    = 160,
    parameter int unsigned CELLS_Y    = 120,
    parameter int unsigned HD         = 640,
    parameter int unsigned VD         = 480,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = 15,
    parameter int unsigned DW         = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [9:0]    pixel_x,
    input  logic [9:0]    pixel_y,
    input  logic          video_enable,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          cpu_wr_valid,
    output logic          cpu_wr_ready,
    input  logic [AW-1:0] cpu_wr_addr,
    input  logic [DW-1:0] cpu_wr_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rgb_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          fifo_empty,
    output logic          addr_err
);

    localparam int unsigned NUM_CELLS = CELLS_X * CELLS_Y;
    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = PW + 1;

    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [DW-1:0] fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic          fetch;
    logic          push;
    logic          pop;
    logic          head_ok;
    logic [AW-1:0] fetch_addr;

    logic          rd_pending;
    logic [DW-1:0] colour;
    logic [1:0]    en_pipe;
    logic [1:0]    hs_pipe;
    logic [1:0]    vs_pipe;

    // Fetch slot: first pixel of each 4-pixel cell inside the active area.
    assign fetch = !reset && video_enable && (pixel_x[1:0] == 2'b00)
                   && (pixel_x < 10'(HD)) && (pixel_y < 10'(VD));

    assign fetch_addr = AW'(pixel_y >> 2) * AW'(CELLS_X) + AW'(pixel_x >> 2);

    assign head_ok    = fifo_addr[rd_ptr] < AW'(NUM_CELLS);
    assign push       = !reset && cpu_wr_valid && cpu_wr_ready;
    assign pop        = !reset && !fetch && (count != '0);
    assign count_next = count + CW'(push) - CW'(pop);

    // RAM port mux: scanout first, then the FIFO head, otherwise idle at address 0.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (fetch) begin
            mem_addr = fetch_addr;
        end else if (pop && head_ok) begin
            mem_addr  = fifo_addr[rd_ptr];
            mem_wdata = fifo_data[rd_ptr];
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_wr_addr;
            fifo_data[wr_ptr] <= cpu_wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cpu_wr_ready <= 1'b1;
            addr_err     <= 1'b0;
            rd_pending   <= 1'b0;
            colour       <= '0;
            en_pipe      <= '0;
            hs_pipe      <= '0;
            vs_pipe      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (pop && !head_ok) begin
                addr_err <= 1'b1;
            end
            count        <= count_next;
            cpu_wr_ready <= (count_next != CW'(FIFO_DEPTH));
            rd_pending   <= fetch;
            if (rd_pending) begin
                colour <= mem_rdata;
            end
            en_pipe <= {en_pipe[0], video_enable};
            hs_pipe <= {hs_pipe[0], hsync_in};
            vs_pipe <= {vs_pipe[0], vsync_in};
        end
    end

    assign rgb_out    = en_pipe[1] ? colour : '0;
    assign hsync_out  = hs_pipe[1];
    assign vsync_out  = vs_pipe[1];
    assign fifo_empty = (count == '0);

endmodule
